// File: rtl/inst_fetch_unit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_pkg : shared types and constants for the instruction fetch    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RECV = 2'd3
  } fetch_state_e;

  localparam int LINE_BYTES     = 64;
  localparam int BEATS_PER_LINE = 8;
  localparam int WIN_BYTES      = 15;
  localparam int REQTAG_W       = 13;

  // Tag layout: {write, io, tag[10:0]}; instruction fetch is a memory read with tag 0.
  localparam logic        REQ_OP_READ  = 1'b0;
  localparam logic        REQ_SP_MEM   = 1'b0;
  localparam logic [REQTAG_W-1:0] FETCH_REQTAG = {REQ_OP_READ, REQ_SP_MEM, 11'd0};

  function automatic logic [63:0] line_base(input logic [63:0] addr);
    return {addr[63:6], 6'b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_fetch_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | inst_fetch_unit_if : system-bus request/response channel            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface inst_fetch_unit_if
  import fetch_pkg::*;
#(
  parameter int TAG_W = REQTAG_W
) ();
  logic             reqcyc;
  logic [63:0]      req;
  logic [TAG_W-1:0] reqtag;
  logic             reqack;
  logic             respcyc;
  logic [63:0]      resp;
  logic             respack;

  modport master (
    output reqcyc, req, reqtag, respack,
    input  reqack, respcyc, resp
  );

  modport slave (
    input  reqcyc, req, reqtag, respack,
    output reqack, respcyc, resp
  );
endinterface
`default_nettype wire

// File: rtl/inst_fetch_unit_byte_ring.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_byte_ring : circular byte queue, masked 8-byte append,        |
// | 0..15-byte pop and a zero-filled 15-byte head window. Rev 1.0       |
// +--------------------------------------------------------------------+
module fetch_byte_ring
  import fetch_pkg::*;
#(
  parameter int BUF_BYTES = 128,
  parameter int PTR_W     = $clog2(BUF_BYTES),
  parameter int CNT_W     = PTR_W + 1
) (
  input  wire logic                   clk,
  input  wire logic                   reset,
  input  wire logic                   flush_i,
  input  wire logic                   wr_en_i,
  input  wire logic [7:0]             wr_mask_i,
  input  wire logic [63:0]            wr_data_i,
  input  wire logic [3:0]             pop_cnt_i,
  output logic      [CNT_W-1:0]       count_o,
  output logic                        pop_ok_o,
  output logic      [8*WIN_BYTES-1:0] win_o
);

  logic [7:0]       mem_q [BUF_BYTES];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;

  logic [2:0]       wr_off [8];
  logic [3:0]       wr_n;
  logic [3:0]       pop_eff;

  // Selected bytes are packed densely at the tail in ascending byte order.
  always_comb begin
    wr_n = 4'd0;
    for (int k = 0; k < 8; k++) begin
      wr_off[k] = wr_n[2:0];
      if (wr_mask_i[k]) wr_n = wr_n + 4'd1;
    end
    if (!wr_en_i) wr_n = 4'd0;
  end

  assign pop_ok_o = (CNT_W'(pop_cnt_i) <= count_q);
  assign pop_eff  = pop_ok_o ? pop_cnt_i : 4'd0;
  assign count_o  = count_q;

  always_ff @(posedge clk) begin
    if (wr_en_i && !flush_i) begin
      for (int k = 0; k < 8; k++) begin
        if (wr_mask_i[k]) mem_q[tail_q + PTR_W'(wr_off[k])] <= wr_data_i[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      tail_q  <= tail_q + PTR_W'(wr_n);
      head_q  <= head_q + PTR_W'(pop_eff);
      count_q <= count_q + CNT_W'(wr_n) - CNT_W'(pop_eff);
    end
  end

  for (genvar k = 0; k < WIN_BYTES; k++) begin : g_win
    logic [PTR_W-1:0] idx;
    assign idx = head_q + PTR_W'(k);
    assign win_o[8*k +: 8] = (count_q > CNT_W'(k)) ? mem_q[idx] : 8'h00;
  end

  a_pop_legal: assert property (@(posedge clk) disable iff (reset) pop_ok_o);

endmodule
`default_nettype wire

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | inst_fetch_unit : line fetch FSM feeding a byte ring for the decoder|
// | Optional FETCH_PERF_CNT_EN adds perf counters. Rev 1.0              |
// +--------------------------------------------------------------------+
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter int BUF_BYTES = 128,
  parameter int TAG_W     = REQTAG_W
) (
  input  wire logic          clk,
  input  wire logic          reset,
  input  wire logic [63:0]   entry,
  input  wire logic          redirect_vld,
  input  wire logic [63:0]   redirect_addr,
  input  wire logic [3:0]    pop_cnt,
  output logic      [119:0]  win_bytes,
  output logic      [7:0]    win_avail,
  output logic      [63:0]   win_addr,
  inst_fetch_unit_if.master  bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic      [31:0]   perf_lines,
  output logic      [31:0]   perf_stall,
  output logic      [31:0]   perf_flush
`endif
);

  localparam int PTR_W = $clog2(BUF_BYTES);
  localparam int CNT_W = PTR_W + 1;

  fetch_state_e state_q;
  logic [63:0]  fetch_pc_q;
  logic [63:0]  req_q;
  logic         reqcyc_q;
  logic [2:0]   beat_q;
  logic         stale_q;
  logic [63:0]  win_addr_q;
  logic [63:0]  win_addr_d;

  logic [CNT_W-1:0] count;
  logic             pop_ok;
  logic             rx_state;
  logic             beat_fire;
  logic [2:0]       beat_idx;
  logic             last_beat;
  logic             has_room;
  logic [7:0]       wr_mask;
  logic             wr_en;

  assign rx_state  = (state_q == WAIT) || (state_q == RECV);
  assign beat_fire = bus.respcyc && rx_state;
  assign beat_idx  = (state_q == WAIT) ? 3'd0 : beat_q;
  assign last_beat = (beat_idx == 3'(BEATS_PER_LINE - 1));
  assign has_room  = (count <= CNT_W'(BUF_BYTES - LINE_BYTES));
  assign wr_en     = beat_fire && !stale_q && !redirect_vld;

  // Bytes of the line below the fetch offset are dropped (only non-zero on the first line).
  always_comb begin
    wr_mask = 8'h00;
    for (int k = 0; k < 8; k++) begin
      wr_mask[k] = ({beat_idx, 3'(k)} >= fetch_pc_q[5:0]);
    end
  end

  fetch_byte_ring #(
    .BUF_BYTES (BUF_BYTES)
  ) u_ring (
    .clk       (clk),
    .reset     (reset),
    .flush_i   (redirect_vld),
    .wr_en_i   (wr_en),
    .wr_mask_i (wr_mask),
    .wr_data_i (bus.resp),
    .pop_cnt_i (pop_cnt),
    .count_o   (count),
    .pop_ok_o  (pop_ok),
    .win_o     (win_bytes)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= entry;
      req_q      <= 64'd0;
      reqcyc_q   <= 1'b0;
      beat_q     <= 3'd0;
      stale_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (redirect_vld) begin
            fetch_pc_q <= redirect_addr;
          end else if (has_room) begin
            state_q  <= REQ;
            reqcyc_q <= 1'b1;
            req_q    <= line_base(fetch_pc_q);
            stale_q  <= 1'b0;
          end
        end
        REQ: begin
          if (bus.reqack) begin
            state_q  <= WAIT;
            reqcyc_q <= 1'b0;
            beat_q   <= 3'd0;
          end
          if (redirect_vld) begin
            fetch_pc_q <= redirect_addr;
            stale_q    <= 1'b1;
          end
        end
        WAIT, RECV: begin
          if (beat_fire) begin
            beat_q  <= beat_idx + 3'd1;
            state_q <= RECV;
            if (last_beat) begin
              state_q <= IDLE;
              if (!stale_q && !redirect_vld) fetch_pc_q <= req_q + 64'(LINE_BYTES);
            end
          end
          if (redirect_vld) begin
            fetch_pc_q <= redirect_addr;
            stale_q    <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    win_addr_d = win_addr_q;
    if (redirect_vld) win_addr_d = redirect_addr;
    else if (pop_ok)  win_addr_d = win_addr_q + 64'(pop_cnt);
  end

  always_ff @(posedge clk) begin
    if (reset) win_addr_q <= entry;
    else       win_addr_q <= win_addr_d;
  end

  assign win_avail   = 8'(count);
  assign win_addr    = win_addr_q;
  assign bus.reqcyc  = reqcyc_q;
  assign bus.req     = req_q;
  assign bus.reqtag  = TAG_W'(FETCH_REQTAG);
  assign bus.respack = bus.respcyc;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_lines_q;
  logic [31:0] perf_stall_q;
  logic [31:0] perf_flush_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_lines_q <= 32'd0;
      perf_stall_q <= 32'd0;
      perf_flush_q <= 32'd0;
    end else begin
      if (wr_en && last_beat)                                perf_lines_q <= perf_lines_q + 32'd1;
      if (!redirect_vld && (count < CNT_W'(WIN_BYTES)))      perf_stall_q <= perf_stall_q + 32'd1;
      if (redirect_vld)                                      perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_lines = perf_lines_q;
  assign perf_stall = perf_stall_q;
  assign perf_flush = perf_flush_q;
`endif

  a_resp_expected: assert property (@(posedge clk) disable iff (reset) bus.respcyc |-> rx_state);

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_inst_fetch_unit : directed + random bench with a byte-stream     |
// | reference model and an in-bench memory responder. Rev 1.0           |
// +--------------------------------------------------------------------+
module tb_inst_fetch_unit;

  logic          clk = 1'b0;
  logic          reset;
  logic [63:0]   entry;
  logic          redirect_vld;
  logic [63:0]   redirect_addr;
  logic [3:0]    pop_cnt;
  logic [119:0]  win_bytes;
  logic [7:0]    win_avail;
  logic [63:0]   win_addr;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]   perf_lines;
  logic [31:0]   perf_stall;
  logic [31:0]   perf_flush;
`endif

  always #5 clk = ~clk;

  inst_fetch_unit_if bif ();

  inst_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .entry         (entry),
    .redirect_vld  (redirect_vld),
    .redirect_addr (redirect_addr),
    .pop_cnt       (pop_cnt),
    .win_bytes     (win_bytes),
    .win_avail     (win_avail),
    .win_addr      (win_addr),
    .bus           (bif.master)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_lines    (perf_lines),
    .perf_stall    (perf_stall),
    .perf_flush    (perf_flush)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the buffer holds the byte stream [m_win, m_tail).
  logic [63:0] m_win, m_tail, m_line, cur_entry, last_req, held_req;
  int          beats_left, beat_idx, lines_done, reqs_seen;
  bit          pend_live, txn_live, prev_cyc, resp_hold;
  int          ack_pct, resp_pct;

  function automatic logic [7:0] mem_byte(input logic [63:0] a);
    logic [63:0] d;
    d = ((a - 64'h1000) >> 6) + {58'd0, a[5:0]};
    return d[7:0];
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic post_checks(input bit rst);
    logic [63:0]  av;
    logic [119:0] ew;
    av = m_tail - m_win;
    ew = '0;
    for (int k = 0; k < 15; k++)
      if (64'(k) < av) ew[8*k +: 8] = mem_byte(m_win + 64'(k));
    chk("win_avail", win_avail, av[7:0]);
    chk("win_addr", win_addr, m_win);
    chk("win_bytes", win_bytes, ew);
    chk("avail_bound", (win_avail <= 8'd128), 1'b1);
    chk("respack", bif.respack, bif.respcyc);
    chk("reqtag", bif.reqtag, fetch_pkg::FETCH_REQTAG);
    if (rst) begin
      chk("reqcyc_rst", bif.reqcyc, 1'b0);
      chk("req_rst", bif.req, 64'd0);
      prev_cyc = 1'b0;
    end else begin
      if (bif.reqcyc && !prev_cyc) begin
        chk("req_addr", bif.req, {m_tail[63:6], 6'b0});
        pend_live = 1'b1;
        last_req  = bif.req;
        held_req  = bif.req;
        reqs_seen++;
      end else if (bif.reqcyc) begin
        chk("req_hold", bif.req, held_req);
      end
      prev_cyc = bif.reqcyc;
    end
  endtask

  task automatic step(input int want, input bit redir, input logic [63:0] raddr, input bit rst);
    logic        cyc_pre;
    logic [63:0] req_pre;
    int          p, av;
    bit          ack, rc;
    cyc_pre = bif.reqcyc;
    req_pre = bif.req;
    av  = int'(m_tail - m_win);
    p   = (want > av) ? av : want;
    if (rst) p = 0;
    ack = !rst && cyc_pre && (int'($urandom_range(0, 99)) < ack_pct);
    rc  = !rst && beats_left > 0 && !resp_hold && (int'($urandom_range(0, 99)) < resp_pct);
    reset         = rst;
    entry         = cur_entry;
    redirect_vld  = redir;
    redirect_addr = raddr;
    pop_cnt       = 4'(p);
    bif.reqack    = ack;
    bif.respcyc   = rc;
    if (rc) begin
      for (int k = 0; k < 8; k++)
        bif.resp[8*k +: 8] = mem_byte(m_line + 64'(8 * beat_idx + k));
    end else begin
      bif.resp = {$urandom, $urandom};
    end
    @(posedge clk);
    if (rst) begin
      m_win = cur_entry; m_tail = cur_entry;
      beats_left = 0; beat_idx = 0; pend_live = 0; txn_live = 0;
    end else begin
      if (redir) begin
        m_win = raddr; m_tail = raddr; pend_live = 0; txn_live = 0;
      end else begin
        if (rc && txn_live) begin
          for (int k = 0; k < 8; k++)
            if (m_line + 64'(8 * beat_idx + k) == m_tail) m_tail = m_tail + 64'd1;
          if (beat_idx == 7) lines_done++;
        end
        m_win = m_win + 64'(p);
      end
      if (rc) begin beat_idx++; beats_left--; end
      if (ack) begin
        m_line = req_pre; beats_left = 8; beat_idx = 0; txn_live = pend_live;
      end
    end
    #1;
    post_checks(rst);
  endtask

  task automatic do_reset(input logic [63:0] e);
    cur_entry = e;
    step(0, 0, 64'd0, 1);
    step(0, 0, 64'd0, 1);
  endtask

  task automatic wait_lines(input int n, input int pop, input int budget);
    int target;
    int i;
    target = lines_done + n;
    i = 0;
    while (lines_done < target && i < budget) begin
      step(pop, 0, 64'd0, 0);
      i++;
    end
    chk("lines_timeout", lines_done, target);
  endtask

  initial begin
    int i, consumed, r0, start;
    reset = 1'b1; entry = 64'h1000; redirect_vld = 1'b0; redirect_addr = 64'd0; pop_cnt = 4'd0;
    bif.reqack = 1'b0; bif.respcyc = 1'b0; bif.resp = 64'd0;
    m_win = 0; m_tail = 0; m_line = 0; last_req = 0; held_req = 0; cur_entry = 64'h1000;
    beats_left = 0; beat_idx = 0; lines_done = 0; reqs_seen = 0;
    pend_live = 0; txn_live = 0; prev_cyc = 0; resp_hold = 0;
    ack_pct = 100; resp_pct = 100;

    // Aligned entry: first full line lands
    do_reset(64'h1000);
    wait_lines(1, 0, 100);
    chk("p1_avail", win_avail, 8'd64);
    chk("p1_byte0", win_bytes[7:0], 8'h00);
    chk("p1_req", last_req, 64'h1000);

    // Unaligned entry: 19 bytes skipped
    do_reset(64'h1013);
    wait_lines(1, 0, 100);
    chk("p2_avail", win_avail, 8'd45);
    chk("p2_addr", win_addr, 64'h1013);
    chk("p2_byte0", win_bytes[7:0], 8'h13);

    // Streaming with full-rate pops
    do_reset(64'h1000);
    start = lines_done;
    for (int n = 0; n < 300; n++) step(15, 0, 64'd0, 0);
    chk("p3_progress", (lines_done - start) >= 20, 1'b1);

    // Redirect mid-line
    do_reset(64'h1000);
    wait_lines(1, 0, 100);
    i = 0;
    while (!(beats_left == 4 && m_line == 64'h1040) && i < 50) begin step(0, 0, 64'd0, 0); i++; end
    chk("p4_reach_beat", beats_left, 4);
    step(0, 1, 64'h2008, 0);
    chk("p4_flush_avail", win_avail, 8'd0);
    chk("p4_flush_addr", win_addr, 64'h2008);
    r0 = reqs_seen; i = 0;
    while (reqs_seen == r0 && i < 50) begin step(0, 0, 64'd0, 0); i++; end
    chk("p4_new_req", last_req, 64'h2000);
    wait_lines(1, 0, 50);
    chk("p4_avail", win_avail, 8'd56);
    chk("p4_byte0", win_bytes[7:0], mem_byte(64'h2008));

    // Pop and full-beat write in the same cycle
    do_reset(64'h1000);
    wait_lines(1, 0, 100);
    resp_hold = 1; i = 0;
    while (beats_left != 8 && i < 20) begin step(0, 0, 64'd0, 0); i++; end
    resp_hold = 0;
    step(10, 0, 64'd0, 0);
    chk("p5_avail", win_avail, 8'd62);
    chk("p5_addr", win_addr, 64'h100A);

    // Window wrapping across the end of the ring (reset lands mid-transaction)
    do_reset(64'h1000);
    i = 0; consumed = 0;
    while (consumed < 123 && i < 200) begin
      step((123 - consumed) > 15 ? 15 : (123 - consumed), 0, 64'd0, 0);
      consumed = int'(m_win - 64'h1000); i++;
    end
    i = 0;
    while (int'(m_tail - m_win) < 20 && i < 50) begin step(0, 0, 64'd0, 0); i++; end
    chk("p6_head", win_addr, 64'h1000 + 64'd123);
    for (int k = 5; k < 15; k++)
      chk("p6_wrap_byte", win_bytes[8*k +: 8], mem_byte(64'h1000 + 64'(123 + k)));

    // Random traffic
    ack_pct = 60; resp_pct = 70;
    do_reset(64'h1000 + 64'($urandom_range(0, 32'h7000)));
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 499) == 0)
        do_reset(64'h1000 + 64'($urandom_range(0, 32'h7000)));
      else if ($urandom_range(0, 99) < 3)
        step(int'($urandom_range(0, 15)), 1, 64'h1000 + 64'($urandom_range(0, 32'h7000)), 0);
      else
        step(int'($urandom_range(0, 15)), 0, 64'd0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
